seven_bit_accumulator: RTL

Sequential 7-bit two's-complement accumulator that sits downstream of the team's 7-bit adder/subtractor datapath. It accepts a stream of add, subtract, load and clear commands over a valid/ready handshake. Each command is applied to an internal accumulator register with the same add/subtract arithmetic as that datapath. The block presents each updated result, with carry, overflow and zero flags, through a one-entry registered output stage with backpressure.

---
 rtl/seven_bit_accumulator.sv | 135 +++++++++++++
 1 files changed

// File: rtl/seven_bit_accumulator.sv
// 7-bit two's-complement accumulator (add/sub/load/clear) with carry, overflow, sticky and zero flags.
// Results appear one cycle after accept in a one-entry output register; in_ready = !out_valid || out_ready.
module seven_bit_accumulator #(
   parameter bit SATURATE = 1'b0
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic [1:0] in_op,
   input  logic [6:0] in_data,
   output logic       out_valid,
   input  logic       out_ready,
   output logic [6:0] out_acc,
   output logic       out_cout,
   output logic       out_ovf,
   output logic       out_ovf_sticky,
   output logic       out_zero
);

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } state_e;

   localparam logic [1:0] OP_ADD  = 2'b00;
   localparam logic [1:0] OP_SUB  = 2'b01;
   localparam logic [1:0] OP_LOAD = 2'b10;
   localparam logic [1:0] OP_CLR  = 2'b11;

   state_e     state_q, state_d;
   logic [6:0] acc_q, acc_d;
   logic       cout_q, cout_d;
   logic       ovf_q, ovf_d;
   logic       sticky_q, sticky_d;

   logic       accept;
   logic       consume;
   logic       sub;
   logic [6:0] operand;
   logic [7:0] sum;
   logic [6:0] raw;
   logic       ovf_w;
   logic [6:0] sat_val;

   assign accept  = in_valid && in_ready;
   assign consume = out_valid && out_ready;

   // Subtract is add of the inverted operand plus one, so cout=1 means no borrow.
   always_comb begin
      sub     = (in_op == OP_SUB);
      operand = in_data ^ {7{sub}};
      sum     = {1'b0, acc_q} + {1'b0, operand} + {7'b0, sub};
      raw     = sum[6:0];
      if (sub) begin
         ovf_w = (acc_q[6] != in_data[6]) && (raw[6] != acc_q[6]);
      end else begin
         ovf_w = (acc_q[6] == in_data[6]) && (raw[6] != acc_q[6]);
      end
      sat_val = acc_q[6] ? 7'h40 : 7'h3F;
   end

   always_comb begin
      acc_d    = acc_q;
      cout_d   = cout_q;
      ovf_d    = ovf_q;
      sticky_d = sticky_q;
      if (accept) begin
         case (in_op)
            OP_ADD, OP_SUB: begin
               acc_d    = (SATURATE && ovf_w) ? sat_val : raw;
               cout_d   = sum[7];
               ovf_d    = ovf_w;
               sticky_d = sticky_q | ovf_w;
            end
            OP_LOAD: begin
               acc_d    = in_data;
               cout_d   = 1'b0;
               ovf_d    = 1'b0;
               sticky_d = 1'b0;
            end
            default: begin
               acc_d    = 7'd0;
               cout_d   = 1'b0;
               ovf_d    = 1'b0;
               sticky_d = 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_q    <= 7'd0;
         cout_q   <= 1'b0;
         ovf_q    <= 1'b0;
         sticky_q <= 1'b0;
      end else begin
         acc_q    <= acc_d;
         cout_q   <= cout_d;
         ovf_q    <= ovf_d;
         sticky_q <= sticky_d;
      end
   end

   // Output-stage state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= EMPTY;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         EMPTY: if (accept) state_d = FULL;
         FULL:  if (consume && !accept) state_d = EMPTY;
         default: state_d = EMPTY;
      endcase
   end

   always_comb begin
      out_valid = (state_q == FULL);
      in_ready  = !out_valid || out_ready;
   end

   assign out_acc        = acc_q;
   assign out_cout       = cout_q;
   assign out_ovf        = ovf_q;
   assign out_ovf_sticky = sticky_q;
   assign out_zero       = (acc_q == 7'd0);

endmodule
